matmul_apb_slave: RTL

//  APB slave front-end of the matmul accelerator; consumes transfers issued by the matmul stimulus/host.

---
 rtl/matmul_apb_slave_if.sv | 27 ++
 rtl/matmul_apb_slave.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/matmul_apb_slave_if.sv
// APB bus bundle between the matmul host and its slave front-end.
// Signal names carry the slave-side direction suffix.
interface matmul_apb_slave_if #(
    parameter int BUS_WIDTH  = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_DIM    = 4
);
    logic                  psel_i;
    logic                  penable_i;
    logic                  pwrite_i;
    logic [MAX_DIM-1:0]    pstrb_i;
    logic [BUS_WIDTH-1:0]  pwdata_i;
    logic [ADDR_WIDTH-1:0] paddr_i;
    logic                  pready_o;
    logic                  pslverr_o;
    logic [BUS_WIDTH-1:0]  prdata_o;

    modport master (
        output psel_i, penable_i, pwrite_i, pstrb_i, pwdata_i, paddr_i,
        input  pready_o, pslverr_o, prdata_o
    );

    modport slave (
        input  psel_i, penable_i, pwrite_i, pstrb_i, pwdata_i, paddr_i,
        output pready_o, pslverr_o, prdata_o
    );
endinterface

// File: rtl/matmul_apb_slave.sv
// APB front-end of the matmul core: CONTROL, operand A/B files, FLAGS and scratchpad reads.
// One fixed wait state (pready two cycles after psel); never stalls beyond that, errors instead.
module matmul_apb_slave #(
    parameter int DATA_WIDTH = 8,
    parameter int BUS_WIDTH  = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
    parameter int LW         = 2 * $clog2(MAX_DIM)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    matmul_apb_slave_if.slave              apb,
    output logic                           busy_o,
    output logic                           start_o,
    output logic [15:0]                    control_o,
    output logic [MAX_DIM*BUS_WIDTH-1:0]   a_rows_o,
    output logic [MAX_DIM*BUS_WIDTH-1:0]   b_cols_o,
    input  logic                           core_busy_i,
    input  logic [BUS_WIDTH-1:0]           flags_i,
    output logic                           sp_rd_en_o,
    output logic [1:0]                     sp_sel_o,
    output logic [LW-1:0]                  sp_rd_addr_o,
    input  logic [BUS_WIDTH-1:0]           sp_rd_data_i
);
    localparam int RW = $clog2(MAX_DIM);
    localparam logic [4:0] REG_CTRL  = 5'h00;
    localparam logic [4:0] REG_A     = 5'h04;
    localparam logic [4:0] REG_B     = 5'h08;
    localparam logic [4:0] REG_FLAGS = 5'h0C;

    typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_e;

    state_e                 state_q, state_d;
    logic [4:0]             region_q, region_d;
    logic [LW-1:0]          line_q, line_d;
    logic                   write_q, write_d;
    logic [BUS_WIDTH-1:0]   wdata_q, wdata_d;
    logic [MAX_DIM-1:0]     strb_q, strb_d;
    logic                   err_q, err_d;
    logic [15:0]            control_q, control_d;
    logic [BUS_WIDTH-1:0]   a_q [MAX_DIM];
    logic [BUS_WIDTH-1:0]   a_d [MAX_DIM];
    logic [BUS_WIDTH-1:0]   b_q [MAX_DIM];
    logic [BUS_WIDTH-1:0]   b_d [MAX_DIM];

    logic [4:0]             in_region;
    logic [LW-1:0]          in_line;
    logic                   in_err;
    logic [RW-1:0]          row_q;
    logic [BUS_WIDTH-1:0]   rdata;
    logic                   unused_paddr;

    assign in_region    = apb.paddr_i[4:0];
    assign in_line      = apb.paddr_i[5+:LW];
    assign unused_paddr = ^apb.paddr_i[ADDR_WIDTH-1:5+LW];
    assign row_q        = line_q[RW-1:0];

    // Error is decided once, when the address is captured; busy_o here equals core_busy_i.
    always_comb begin
        in_err = 1'b0;
        if (in_region[1:0] != 2'b00)
            in_err = 1'b1;
        else if (apb.pwrite_i && (in_region[4] || in_region == REG_FLAGS))
            in_err = 1'b1;
        else if (apb.pwrite_i && busy_o)
            in_err = 1'b1;
        else if ((in_region == REG_A || in_region == REG_B) && in_line[LW-1:RW] != '0)
            in_err = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        region_d  = region_q;
        line_d    = line_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        err_d     = err_q;
        control_d = control_q;
        a_d       = a_q;
        b_d       = b_q;
        case (state_q)
            IDLE: begin
                if (apb.psel_i) begin
                    state_d  = SETUP;
                    region_d = in_region;
                    line_d   = in_line;
                    write_d  = apb.pwrite_i;
                    wdata_d  = apb.pwdata_i;
                    strb_d   = apb.pstrb_i;
                    err_d    = in_err;
                end
            end
            SETUP: begin
                if (!apb.psel_i) begin
                    state_d = IDLE;
                end else if (apb.penable_i) begin
                    state_d = ACCESS;
                    if (write_q && !err_q) begin
                        if (region_q == REG_CTRL) begin
                            if (strb_q[0]) control_d[7:0]  = wdata_q[7:0];
                            if (strb_q[1]) control_d[15:8] = wdata_q[15:8];
                            control_d[0] = 1'b0;
                        end
                        for (int l = 0; l < MAX_DIM; l++) begin
                            if (strb_q[l] && region_q == REG_A)
                                a_d[row_q][l*DATA_WIDTH +: DATA_WIDTH] = wdata_q[l*DATA_WIDTH +: DATA_WIDTH];
                            if (strb_q[l] && region_q == REG_B)
                                b_d[row_q][l*DATA_WIDTH +: DATA_WIDTH] = wdata_q[l*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                end
            end
            ACCESS:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            region_q  <= '0;
            line_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            err_q     <= 1'b0;
            control_q <= '0;
            for (int r = 0; r < MAX_DIM; r++) begin
                a_q[r] <= '0;
                b_q[r] <= '0;
            end
        end else begin
            state_q   <= state_d;
            region_q  <= region_d;
            line_q    <= line_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            err_q     <= err_d;
            control_q <= control_d;
            a_q       <= a_d;
            b_q       <= b_d;
        end
    end

    // Every aligned region not matched explicitly is a scratchpad window.
    always_comb begin
        rdata = '0;
        if (state_q == ACCESS && !write_q && !err_q) begin
            case (region_q)
                REG_CTRL:  rdata = {{(BUS_WIDTH-16){1'b0}}, control_q};
                REG_A:     rdata = a_q[row_q];
                REG_B:     rdata = b_q[row_q];
                REG_FLAGS: rdata = flags_i;
                default:   rdata = sp_rd_data_i;
            endcase
        end
    end

    assign apb.pready_o  = (state_q == ACCESS);
    assign apb.pslverr_o = (state_q == ACCESS) && err_q;
    assign apb.prdata_o  = rdata;

    assign start_o   = (state_q == ACCESS) && write_q && !err_q && (region_q == REG_CTRL) && wdata_q[0];
    assign busy_o    = start_o | core_busy_i;
    assign control_o = control_q;

    assign sp_rd_en_o   = (state_q == SETUP) && !write_q && !err_q && region_q[4];
    assign sp_sel_o     = sp_rd_en_o ? region_q[3:2] : 2'b00;
    assign sp_rd_addr_o = sp_rd_en_o ? line_q : '0;

    for (genvar r = 0; r < MAX_DIM; r++) begin : g_pack
        assign a_rows_o[r*BUS_WIDTH +: BUS_WIDTH] = a_q[r];
        assign b_cols_o[r*BUS_WIDTH +: BUS_WIDTH] = b_q[r];
    end
endmodule
